// File: rtl/ctx_switch_pkg.sv
// ctx_switch_pkg: shared types for the timer preemption consumer.
// State encoding for the switch FSM and PID/PC widths.
package ctx_switch_pkg;

    localparam int PID_W = 32;
    localparam int PC_W  = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PENDING  = 3'd1,
        SAVE     = 3'd2,
        DISPATCH = 3'd3,
        WAIT_ACK = 3'd4,
        RESUME   = 3'd5
    } state_t;

endpackage

// File: rtl/context_switch_ctrl_rr_pid_picker.sv
// rr_pid_picker: combinational round-robin choice of the next user PID.
// Ports: procValid (runnable mask), startPid (last PID run), pick (chosen PID, 0 if none).
module rr_pid_picker
    import ctx_switch_pkg::*;
#(
    parameter int NUM_PROCS = 8
) (
    input  logic [NUM_PROCS-1:0] procValid,
    input  logic [PID_W-1:0]     startPid,
    output logic [PID_W-1:0]     pick
);

    localparam int IW = $clog2(NUM_PROCS);

    logic [PID_W-1:0] base;
    logic [PID_W-1:0] idx;

    // User PIDs 1..NUM_PROCS-1 form a ring; slot 0 never takes part.
    // Walking backwards lets the smallest offset win.
    always_comb begin
        base = (startPid >= PID_W'(NUM_PROCS)) ? '0 : startPid;
        pick = '0;
        idx  = '0;
        for (int off = NUM_PROCS - 1; off >= 1; off--) begin
            idx = ((base + PID_W'(off) - PID_W'(1))
                   % PID_W'(NUM_PROCS - 1)) + PID_W'(1);
            if (procValid[idx[IW-1:0]]) begin
                pick = idx;
            end
        end
    end

endmodule

// File: rtl/context_switch_ctrl.sv
// context_switch_ctrl: latches timer preemption, saves PC/PID, redirects fetch, picks next PID.
// Ports: clock/reset, timer+CPU status in, pcSel/save/next/timer control out; missCnt with IRQ_MISS_CNT_EN.
module context_switch_ctrl
    import ctx_switch_pkg::*;
#(
    parameter int          NUM_PROCS    = 8,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0004
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 interrupt,
    input  logic                 halt,
    input  logic [PID_W-1:0]     curPid,
    input  logic [PC_W-1:0]      curPc,
    input  logic                 instrDone,
    input  logic [NUM_PROCS-1:0] procValid,
    input  logic                 swAck,
    output logic                 irqReq,
    output logic                 pcSel,
    output logic [PC_W-1:0]      handlerPc,
    output logic [PC_W-1:0]      savePc,
    output logic [PID_W-1:0]     savePid,
    output logic [PID_W-1:0]     nextPid,
    output logic                 timerBlock,
    output logic                 timerReset,
    output logic                 busy
`ifdef IRQ_MISS_CNT_EN
    ,
    output logic [15:0]          missCnt
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic [PID_W-1:0] pick;

    assign handlerPc = HANDLER_ADDR;
    assign accept    = (state == IDLE) && interrupt &&
                       (curPid != '0) && !halt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs decode from state only, so an async reset
    // drops pcSel/timerBlock without waiting for a clock.
    always_comb begin
        state_nxt  = state;
        irqReq     = 1'b0;
        pcSel      = 1'b0;
        timerBlock = 1'b0;
        timerReset = 1'b0;
        busy       = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (accept) state_nxt = PENDING;
            end
            PENDING: begin
                irqReq = 1'b1;
                if (halt) begin
                    state_nxt = IDLE;
                end else if (instrDone) begin
                    state_nxt = SAVE;
                end
            end
            SAVE: begin
                pcSel      = 1'b1;
                timerBlock = 1'b1;
                state_nxt  = DISPATCH;
            end
            DISPATCH: begin
                timerBlock = 1'b1;
                state_nxt  = WAIT_ACK;
            end
            WAIT_ACK: begin
                timerBlock = 1'b1;
                if (swAck) state_nxt = RESUME;
            end
            RESUME: begin
                timerReset = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // DISPATCH sees the savePid written in SAVE.
    rr_pid_picker #(
        .NUM_PROCS (NUM_PROCS)
    ) u_picker (
        .procValid (procValid),
        .startPid  (savePid),
        .pick      (pick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            savePc  <= '0;
            savePid <= '0;
            nextPid <= '0;
        end else begin
            if (state == SAVE) begin
                savePc  <= curPc;
                savePid <= curPid;
            end
            if (state == DISPATCH) begin
                nextPid <= pick;
            end
        end
    end

`ifdef IRQ_MISS_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            missCnt <= '0;
        end else if (interrupt && !accept && (missCnt != 16'hFFFF)) begin
            missCnt <= missCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_context_switch_ctrl.sv
// tb_context_switch_ctrl: vector table of switches plus hand sequences.
// Scoreboard holds expected save/next values per accepted interrupt.
module tb_context_switch_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        interrupt = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] curPid = '0;
    logic [31:0] curPc = '0;
    logic        instrDone = 1'b0;
    logic [7:0]  procValid = '0;
    logic        swAck = 1'b0;
    logic        irqReq;
    logic        pcSel;
    logic [31:0] handlerPc;
    logic [31:0] savePc;
    logic [31:0] savePid;
    logic [31:0] nextPid;
    logic        timerBlock;
    logic        timerReset;
    logic        busy;
`ifdef IRQ_MISS_CNT_EN
    logic [15:0] missCnt;
`endif

    context_switch_ctrl #(
        .NUM_PROCS    (8),
        .HANDLER_ADDR (32'h0000_0004)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .interrupt  (interrupt),
        .halt       (halt),
        .curPid     (curPid),
        .curPc      (curPc),
        .instrDone  (instrDone),
        .procValid  (procValid),
        .swAck      (swAck),
        .irqReq     (irqReq),
        .pcSel      (pcSel),
        .handlerPc  (handlerPc),
        .savePc     (savePc),
        .savePid    (savePid),
        .nextPid    (nextPid),
        .timerBlock (timerBlock),
        .timerReset (timerReset),
        .busy       (busy)
`ifdef IRQ_MISS_CNT_EN
        ,
        .missCnt    (missCnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pid;
        logic [7:0]  valid;
        logic [31:0] pc;
        logic [31:0] exp_next;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pid;
        logic [31:0] nxt;
    } exp_t;

    vec_t vecs [7];
    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;
    int   exp_miss = 0;
    logic [31:0] last_pc;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, a, e);
        end
    endtask

    task automatic chk_miss(input string n);
`ifdef IRQ_MISS_CNT_EN
        chk(n, 32'(missCnt), 32'(exp_miss));
`endif
    endtask

    task automatic to_wait(input logic [31:0] pid, input logic [31:0] pc,
                           input logic [7:0] v, input logic [31:0] en);
        exp_t e;
        curPid    = pid;
        curPc     = pc;
        procValid = v;
        interrupt = 1'b1;
        e.pc  = pc;
        e.pid = pid;
        e.nxt = en;
        sb.push_back(e);
        step;
        interrupt = 1'b0;
        chk("irq_c1", 32'(irqReq), 1);
        chk("busy_pend", 32'(busy), 1);
        step;
        chk("irq_c2", 32'(irqReq), 1);
        chk("pcsel_pend", 32'(pcSel), 0);
        instrDone = 1'b1;
        step;
        instrDone = 1'b0;
        chk("pcsel_save", 32'(pcSel), 1);
        chk("irq_save", 32'(irqReq), 0);
        chk("tblock_save", 32'(timerBlock), 1);
        step;
        chk("pcsel_off", 32'(pcSel), 0);
        chk("tblock_disp", 32'(timerBlock), 1);
        step;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow actual=0 required=1");
        end else begin
            e = sb.pop_front();
            chk("savePc", savePc, e.pc);
            chk("savePid", savePid, e.pid);
            chk("nextPid", nextPid, e.nxt);
        end
        chk("tblock_wait", 32'(timerBlock), 1);
    endtask

    task automatic finish_ack;
        step;
        step;
        chk("tblock_hold", 32'(timerBlock), 1);
        chk("treset_hold", 32'(timerReset), 0);
        chk("busy_hold", 32'(busy), 1);
        swAck = 1'b1;
        step;
        swAck = 1'b0;
        chk("treset", 32'(timerReset), 1);
        chk("tblock_resume", 32'(timerBlock), 0);
        step;
        chk("treset_off", 32'(timerReset), 0);
        chk("busy_idle", 32'(busy), 0);
    endtask

    initial begin
        vecs[0] = '{32'd3,  8'b0011_1010, 32'h0000_1000, 32'd4};
        vecs[1] = '{32'd5,  8'b0010_0110, 32'h0000_1004, 32'd1};
        vecs[2] = '{32'd5,  8'b0000_0001, 32'h0000_1008, 32'd0};
        vecs[3] = '{32'd7,  8'b1000_0000, 32'h0000_100C, 32'd7};
        vecs[4] = '{32'd12, 8'b0100_0100, 32'h0000_1010, 32'd2};
        vecs[5] = '{32'd2,  8'b1111_1111, 32'h0000_1014, 32'd3};
        vecs[6] = '{32'd6,  8'b1000_0001, 32'h0000_1018, 32'd7};

        step;
        step;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_irq", 32'(irqReq), 0);
        chk("rst_pcsel", 32'(pcSel), 0);
        chk("rst_tblock", 32'(timerBlock), 0);
        chk("rst_savepc", savePc, 0);
        chk("rst_nextpid", nextPid, 0);
        chk("rst_handler", handlerPc, 32'h0000_0004);
        chk_miss("rst_miss");
        reset = 1'b1;
        step;

        for (int i = 0; i < 7; i++) begin
            to_wait(vecs[i].pid, vecs[i].pc, vecs[i].valid,
                    vecs[i].exp_next);
            finish_ack;
        end
        last_pc = vecs[6].pc;
        chk("sb_empty", 32'(sb.size()), 0);

        curPid    = 32'd0;
        interrupt = 1'b1;
        step;
        interrupt = 1'b0;
        exp_miss++;
        chk("kpid_busy", 32'(busy), 0);
        chk("kpid_irq", 32'(irqReq), 0);
        chk_miss("kpid_miss");
        curPid    = 32'd3;
        halt      = 1'b1;
        interrupt = 1'b1;
        step;
        interrupt = 1'b0;
        halt      = 1'b0;
        exp_miss++;
        chk("halt_busy", 32'(busy), 0);
        chk("halt_irq", 32'(irqReq), 0);
        chk_miss("halt_miss");

        swAck = 1'b1;
        step;
        swAck = 1'b0;
        chk("idle_ack_busy", 32'(busy), 0);
        chk("idle_ack_treset", 32'(timerReset), 0);

        curPid    = 32'd3;
        curPc     = 32'h0000_2000;
        interrupt = 1'b1;
        step;
        interrupt = 1'b0;
        chk("hp_irq", 32'(irqReq), 1);
        halt      = 1'b1;
        instrDone = 1'b1;
        step;
        halt      = 1'b0;
        instrDone = 1'b0;
        chk("hp_busy", 32'(busy), 0);
        chk("hp_pcsel", 32'(pcSel), 0);
        chk("hp_irq_off", 32'(irqReq), 0);
        step;
        chk("hp_pcsel2", 32'(pcSel), 0);
        chk("hp_savepc", savePc, last_pc);
        chk_miss("hp_miss");

        to_wait(32'd4, 32'h0000_3000, 8'b0000_0110, 32'd1);
        interrupt = 1'b1;
        step;
        interrupt = 1'b0;
        exp_miss++;
        chk("wa_irq_busy", 32'(busy), 1);
        chk("wa_irq_irq", 32'(irqReq), 0);
        chk_miss("wa_miss");
        finish_ack;

        to_wait(32'd1, 32'h0000_4000, 8'b0000_1000, 32'd3);
        reset = 1'b0;
        #1;
        chk("ar_tblock", 32'(timerBlock), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_savepc", savePc, 0);
        chk("ar_nextpid", nextPid, 0);
        exp_miss = 0;
        chk_miss("ar_miss");
        step;
        reset = 1'b1;
        step;
        to_wait(32'd2, 32'h0000_5000, 8'b0010_0001, 32'd5);
        finish_ack;
        chk("end_handler", handlerPc, 32'h0000_0004);
        chk("end_sb_empty", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
